// File: rtl/rv32_pkg.sv
// Shared fetch-stage types and constants.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package rv32_pkg;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,   // no request on the bus; waiting for buffer space
    REQ,    // request presented, waiting for accept
    WAIT,   // request accepted, response pending
    DRAIN   // response pending that belongs to a squashed path
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small fetch buffer holding {pc, instr} pairs between memory and ID.
// Latency: push visible at head the cycle after the write edge.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
//
// Ports: clk/rst_n; push + push_dat write; pop advances head;
//        flush empties the buffer and wins over push/pop;
//        head is the oldest entry; count/empty/full report occupancy.
module fetch_fifo
  import rv32_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  fetch_entry_t           push_dat,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = pop && !empty;
  // A full buffer can still take a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, fetches words from imem, buffers them for ID.
// Latency: first instr_valid 3 cycles after reset release with a zero-wait memory.
// Backpressure: stall holds the head; new requests issue only while buffer space remains.
//
// Ports: clk/rst_n; imem_req_* valid/ready request channel; imem_rsp_* valid-only
//        response channel (in order, one per accepted request); redirect_* from EX;
//        stall from hazard logic; instruction/pc/instr_valid to ID.
module if_stage
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        instr_valid
);

  localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  fetch_state_t  state;
  fetch_state_t  state_nxt;
  logic [31:0]   fetch_pc;
  logic [31:0]   fetch_pc_nxt;
  logic [31:0]   req_addr;
  logic          req_vld;
  // Redirect seen while a request sat unaccepted; its response must be dropped.
  logic          drain_pend;
  logic          drain_nxt;

  fetch_entry_t  head;
  fetch_entry_t  push_dat;
  logic [CW-1:0] count;
  logic [CW-1:0] count_after;
  logic          fifo_empty;
  logic          fifo_full;
  logic          accept;
  logic          push;
  logic          pop;
  logic          space;

  assign accept   = req_vld && imem_req_ready;
  assign pop      = !fifo_empty && !stall;
  assign push     = (state == WAIT) && imem_rsp_valid && !redirect_valid
                    && (!fifo_full || pop);
  assign push_dat = '{pc: req_addr, instr: imem_rsp_data};

  // Occupancy after this edge; every branch that consults it leaves nothing
  // outstanding, so this alone decides whether another request may issue.
  always_comb begin
    count_after = count;
    if (redirect_valid) begin
      count_after = '0;
    end else if (push && !pop) begin
      count_after = count + 1'b1;
    end else if (!push && pop) begin
      count_after = count - 1'b1;
    end
  end

  assign space = (count_after < DEPTH_C);

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    drain_nxt    = drain_pend;
    if (redirect_valid) begin
      fetch_pc_nxt = redirect_pc & ~32'h3;
    end
    unique case (state)
      IDLE: begin
        if (space) state_nxt = REQ;
      end
      REQ: begin
        if (accept) begin
          drain_nxt = 1'b0;
          if (drain_pend || redirect_valid) begin
            // Old-path request went out; fetch_pc already holds the target.
            state_nxt = DRAIN;
          end else begin
            state_nxt    = WAIT;
            fetch_pc_nxt = fetch_pc + 32'd4;
          end
        end else if (redirect_valid) begin
          drain_nxt = 1'b1;
        end
      end
      WAIT: begin
        // A response coinciding with a redirect retires the outstanding
        // request, so there is nothing left to drain.
        if (imem_rsp_valid) begin
          state_nxt = space ? REQ : IDLE;
        end else if (redirect_valid) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (imem_rsp_valid) begin
          state_nxt = space ? REQ : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      req_addr   <= RESET_PC;
      req_vld    <= 1'b0;
      drain_pend <= 1'b0;
    end else begin
      state      <= state_nxt;
      fetch_pc   <= fetch_pc_nxt;
      drain_pend <= drain_nxt;
      req_vld    <= (state_nxt == REQ);
      // Address is captured on entry to REQ and held until accepted.
      if (state_nxt == REQ && state != REQ) begin
        req_addr <= fetch_pc_nxt;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .flush    (redirect_valid),
    .head     (head),
    .count    (count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign imem_req_valid = req_vld;
  assign imem_req_addr  = req_addr;
  assign instr_valid    = !fifo_empty;
  assign instruction    = fifo_empty ? NOP_INSTR : head.instr;
  assign pc             = fifo_empty ? 32'h0 : head.pc;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        instr_valid;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .instruction    (instruction),
    .pc             (pc),
    .instr_valid    (instr_valid)
  );

  int total = 0;
  int bad   = 0;

  // memory model controls: rdy_mode 0=random, 1=always ready, 2=never ready
  int          rdy_mode = 1;
  int          dly_min  = 0;
  int          dly_max  = 0;
  bit          mem_busy = 0;
  int          mem_wait = 0;
  logic [31:0] mem_addr;
  bit          acc_flag;
  logic [31:0] acc_addr;
  logic [31:0] last_acc, prev_acc;

  // reference model: ID sees a linear stream of word addresses with their
  // memory contents, restarting at the aligned target after each redirect
  logic [31:0] exp_pc;
  int          consumed = 0;

  bit          hold_chk, stall_chk, redir_chk;
  logic [31:0] hold_addr, held_pc, held_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00a0_0113;
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: inspect what the coming edge will do, wait for the following
  // negedge, check the results, then drive memory for the next edge.
  task automatic tick();
    acc_flag  = 0;
    hold_chk  = 0;
    stall_chk = 0;
    redir_chk = 0;
    if (rst_n) begin
      if (redirect_valid) begin
        exp_pc    = redirect_pc & ~32'h3;
        redir_chk = 1;
      end else if (instr_valid && !stall) begin
        chk("seq_pc", pc, exp_pc);
        chk("seq_instr", instruction, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      if (imem_req_valid && imem_req_ready) begin
        chk("one_outstanding", {31'd0, mem_busy}, 32'd0);
        acc_flag = 1;
        acc_addr = imem_req_addr;
        prev_acc = last_acc;
        last_acc = imem_req_addr;
      end
      hold_chk   = imem_req_valid && !imem_req_ready;
      hold_addr  = imem_req_addr;
      stall_chk  = instr_valid && stall && !redirect_valid;
      held_pc    = pc;
      held_instr = instruction;
    end
    @(negedge clk);
    if (rst_n) begin
      if (hold_chk) begin
        chk("req_hold_vld", imem_req_valid, 1);
        chk("req_hold_addr", imem_req_addr, hold_addr);
      end
      if (stall_chk) begin
        chk("stall_vld", instr_valid, 1);
        chk("stall_pc", pc, held_pc);
        chk("stall_instr", instruction, held_instr);
      end
      if (redir_chk) chk("flush_vld", instr_valid, 0);
      if (!instr_valid) begin
        chk("empty_instr", instruction, NOP);
        chk("empty_pc", pc, 0);
      end
    end
    imem_rsp_valid = 0;
    if (acc_flag) begin
      mem_busy = 1;
      mem_addr = acc_addr;
      mem_wait = $urandom_range(dly_max, dly_min);
    end
    if (mem_busy) begin
      if (mem_wait == 0) begin
        imem_rsp_valid = 1;
        imem_rsp_data  = mem_word(mem_addr);
        mem_busy       = 0;
      end else begin
        mem_wait--;
      end
    end
    case (rdy_mode)
      0:       imem_req_ready = ($urandom_range(3, 0) != 0);
      1:       imem_req_ready = 1;
      default: imem_req_ready = 0;
    endcase
  endtask

  task automatic wait_vld(input string tag);
    int n = 0;
    while (!instr_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_vld"}, instr_valid, 1);
  endtask

  task automatic wait_req(input string tag, input logic [31:0] want);
    int n = 0;
    while (!imem_req_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_vld"}, imem_req_valid, 1);
    chk({tag, "_addr"}, imem_req_addr, want);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req_vld"}, imem_req_valid, 0);
    chk({tag, "_req_addr"}, imem_req_addr, 32'h0);
    chk({tag, "_ivld"}, instr_valid, 0);
    chk({tag, "_instr"}, instruction, NOP);
    chk({tag, "_pc"}, pc, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    int          n;
    int          base;

    rst_n          = 0;
    stall          = 0;
    redirect_valid = 0;
    redirect_pc    = 0;
    imem_req_ready = 1;
    imem_rsp_valid = 0;
    imem_rsp_data  = 0;
    last_acc       = 0;
    prev_acc       = 0;
    exp_pc         = 0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");

    // 1: zero-wait memory, first instruction 3 cycles after release
    rst_n = 1;
    tick(); chk("lat_c1", instr_valid, 0);
    tick(); chk("lat_c2", instr_valid, 0);
    tick();
    chk("lat_c3_vld", instr_valid, 1);
    chk("lat_c3_pc", pc, 32'h0);
    chk("lat_c3_instr", instruction, 32'h0050_0093);
    tick();
    wait_vld("t1_second");
    chk("t1_second_pc", pc, 32'h4);
    chk("t1_second_instr", instruction, 32'h00a0_0113);

    // 2: stall fills the buffer and stops requesting
    stall = 1;
    repeat (6) tick();
    chk("t2_req_idle", imem_req_valid, 0);
    chk("t2_frozen_vld", instr_valid, 1);
    chk("t2_frozen_pc", pc, 32'h4);
    stall = 0;
    tick();
    chk("t2_next_vld", instr_valid, 1);
    chk("t2_next_pc", pc, 32'h8);

    // 3: memory refuses requests for 4 cycles
    rdy_mode = 2;
    n = 0;
    while (!(imem_req_valid && !imem_req_ready) && n < 40) begin tick(); n++; end
    chk("t3_blocked", imem_req_valid && !imem_req_ready, 1);
    held = imem_req_addr;
    repeat (3) begin
      tick();
      chk("t3_addr_held", imem_req_addr, held);
    end
    rdy_mode = 1;
    tick();
    n = 0;
    while (!(instr_valid && pc == held) && n < 20) begin tick(); n++; end
    chk("t3_rsp_pc", pc, held);
    chk("t3_rsp_instr", instruction, mem_word(held));

    // 4: redirect while a fetch is outstanding (with buffered entries)
    dly_min = 1; dly_max = 1;
    stall = 1;
    n = 0;
    while (!mem_busy && n < 40) begin tick(); n++; end
    chk("t4_in_wait", mem_busy, 1);
    redirect_valid = 1; redirect_pc = 32'h103;
    tick();
    redirect_valid = 0; stall = 0;
    chk("t4_flushed", instr_valid, 0);
    wait_req("t4_req", 32'h100);
    wait_vld("t4_out");
    chk("t4_out_pc", pc, 32'h100);
    chk("t4_out_instr", instruction, mem_word(32'h100));

    // 5: redirect in the same cycle as a response
    dly_min = 0; dly_max = 0;
    n = 0;
    while (!imem_rsp_valid && n < 40) begin tick(); n++; end
    chk("t5_rsp_seen", imem_rsp_valid, 1);
    redirect_valid = 1; redirect_pc = 32'h2000;
    tick();
    redirect_valid = 0;
    chk("t5_no_push", instr_valid, 0);
    wait_req("t5_req", 32'h2000);
    wait_vld("t5_out");
    chk("t5_out_pc", pc, 32'h2000);

    // 6: fetch_pc wraps at the top of the address space
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 0;
    wait_vld("t6_top");
    chk("t6_top_pc", pc, 32'hFFFF_FFFC);
    tick();
    wait_vld("t6_wrap");
    chk("t6_wrap_pc", pc, 32'h0);
    chk("t6_wrap_instr", instruction, 32'h0050_0093);
    chk("t6_acc_prev", prev_acc, 32'hFFFF_FFFC);
    chk("t6_acc_last", last_acc, 32'h0);

    // reset pulse while a fetch is outstanding
    dly_min = 1; dly_max = 1;
    n = 0;
    while (!mem_busy && n < 40) begin tick(); n++; end
    chk("rst_in_wait", mem_busy, 1);
    rst_n          = 0;
    mem_busy       = 0;
    imem_rsp_valid = 0;
    #1;
    check_reset_vals("midrst");
    tick();
    tick();
    rst_n  = 1;
    exp_pc = 32'h0;
    wait_vld("midrst_out");
    chk("midrst_out_pc", pc, 32'h0);

    // random traffic against the stream model
    rdy_mode = 0; dly_min = 0; dly_max = 2;
    base = consumed;
    for (int i = 0; i < 3000; i++) begin
      stall = ($urandom_range(3, 0) == 0);
      if ($urandom_range(19, 0) == 0) begin
        redirect_valid = 1;
        case ($urandom_range(2, 0))
          0:       redirect_pc = $urandom;
          1:       redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
          default: redirect_pc = 32'($urandom_range(255, 0));
        endcase
      end else begin
        redirect_valid = 0;
      end
      tick();
    end
    stall = 0; redirect_valid = 0;
    repeat (10) tick();
    chk("rand_progress", (consumed - base) > 100, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
